// File: rtl/avalon_pio_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | avalon_pio_pkg                                                         |
// | Register map and edge-type encodings shared by the PIO port.           |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package avalon_pio_pkg;

   localparam int BUS_WIDTH = 32;
   localparam int ADDR_WIDTH = 3;

   localparam logic [ADDR_WIDTH-1:0] ADDR_DATA         = 3'd0;
   localparam logic [ADDR_WIDTH-1:0] ADDR_DIRECTION    = 3'd1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_IRQ_MASK     = 3'd2;
   localparam logic [ADDR_WIDTH-1:0] ADDR_EDGE_CAPTURE = 3'd3;
   localparam logic [ADDR_WIDTH-1:0] ADDR_OUTSET       = 3'd4;
   localparam logic [ADDR_WIDTH-1:0] ADDR_OUTCLEAR     = 3'd5;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

endpackage : avalon_pio_pkg
`default_nettype wire

// File: rtl/avalon_pio_gen2_sync_edge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pio_sync_edge                                                          |
// | Multi-stage input synchroniser with per-bit edge detection.            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pio_sync_edge
   import avalon_pio_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISING
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] async_in,
   output logic [DATA_WIDTH-1:0] sync_out,
   output logic [DATA_WIDTH-1:0] edge_pulse
);

   logic [DATA_WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [DATA_WIDTH-1:0] prev_d;
   logic [DATA_WIDTH-1:0] prev_q;

   always_comb begin
      sync_d[0] = async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         prev_q <= '0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         prev_q <= prev_d;
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   // prev_q starts at zero, so a pin already high at reset release reports a rising edge.
   generate
      if (EDGE_TYPE == EDGE_FALLING) begin : g_falling
         assign edge_pulse = ~sync_out & prev_q;
      end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
         assign edge_pulse = sync_out ^ prev_q;
      end else begin : g_rising
         assign edge_pulse = sync_out & ~prev_q;
      end
   endgenerate

endmodule : pio_sync_edge
`default_nettype wire

// File: rtl/avalon_pio_gen2.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | avalon_pio_gen2                                                        |
// | Zero-wait-state Avalon-MM PIO with direction, set/clear, edge IRQ.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module avalon_pio_gen2
   import avalon_pio_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter int                    EDGE_TYPE   = EDGE_RISING,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [BUS_WIDTH-1:0]  writedata,
   output logic [BUS_WIDTH-1:0]  readdata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic [DATA_WIDTH-1:0] out_oe,
   output logic                  irq
);

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  unused_wdata;

   logic [DATA_WIDTH-1:0] sync_in;
   logic [DATA_WIDTH-1:0] edge_pulse;

   logic [DATA_WIDTH-1:0] data_out_d, data_out_q;
   logic [DATA_WIDTH-1:0] direction_d, direction_q;
   logic [DATA_WIDTH-1:0] irq_mask_d, irq_mask_q;
   logic [DATA_WIDTH-1:0] edge_capture_d, edge_capture_q;
   logic [DATA_WIDTH-1:0] edge_clear;
   logic                  irq_d, irq_q;
   logic [DATA_WIDTH-1:0] rd_word;

   assign wr_en        = chipselect & ~write_n;
   assign wdata        = writedata[DATA_WIDTH-1:0];
   assign unused_wdata = ^writedata;

   pio_sync_edge #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync_edge (
      .clk        (clk),
      .reset_n    (reset_n),
      .async_in   (in_port),
      .sync_out   (sync_in),
      .edge_pulse (edge_pulse)
   );

   always_comb begin
      data_out_d  = data_out_q;
      direction_d = direction_q;
      irq_mask_d  = irq_mask_q;
      edge_clear  = '0;
      if (wr_en) begin
         case (address)
            ADDR_DATA:         data_out_d  = wdata;
            ADDR_DIRECTION:    direction_d = wdata;
            ADDR_IRQ_MASK:     irq_mask_d  = wdata;
            ADDR_EDGE_CAPTURE: edge_clear  = wdata;
            ADDR_OUTSET:       data_out_d  = data_out_q | wdata;
            ADDR_OUTCLEAR:     data_out_d  = data_out_q & ~wdata;
            default:           ;
         endcase
      end
      // A new edge overrides a simultaneous write-1-to-clear of the same bit.
      edge_capture_d = (edge_capture_q & ~edge_clear) | edge_pulse;
      irq_d          = |(edge_capture_d & irq_mask_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out_q     <= RESET_VALUE;
         direction_q    <= '0;
         irq_mask_q     <= '0;
         edge_capture_q <= '0;
         irq_q          <= 1'b0;
      end else begin
         data_out_q     <= data_out_d;
         direction_q    <= direction_d;
         irq_mask_q     <= irq_mask_d;
         edge_capture_q <= edge_capture_d;
         irq_q          <= irq_d;
      end
   end

   always_comb begin
      rd_word = '0;
      case (address)
         ADDR_DATA:         rd_word = (direction_q & data_out_q) | (~direction_q & sync_in);
         ADDR_DIRECTION:    rd_word = direction_q;
         ADDR_IRQ_MASK:     rd_word = irq_mask_q;
         ADDR_EDGE_CAPTURE: rd_word = edge_capture_q;
         default:           rd_word = '0;
      endcase
      readdata                 = '0;
      readdata[DATA_WIDTH-1:0] = rd_word;
   end

   assign out_port = data_out_q;
   assign out_oe   = direction_q;
   assign irq      = irq_q;

endmodule : avalon_pio_gen2
`default_nettype wire

// File: tb/tb_avalon_pio_gen2.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_avalon_pio_gen2                                                     |
// | Directed stimulus with a queue-based scoreboard and negedge monitor.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_avalon_pio_gen2;

    localparam int DW = 8;
    localparam int SEL_RDATA = 0;
    localparam int SEL_OUT   = 1;
    localparam int SEL_OE    = 2;
    localparam int SEL_IRQ   = 3;
    localparam int MIN_CHECKS = 12;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic [2:0]    address    = 3'd0;
    logic          chipselect = 1'b0;
    logic          write_n    = 1'b1;
    logic [31:0]   writedata  = 32'h0;
    logic [31:0]   readdata;
    logic [DW-1:0] in_port    = '0;
    logic [DW-1:0] out_port;
    logic [DW-1:0] out_oe;
    logic          irq;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] act;

    always #5 clk = ~clk;

    avalon_pio_gen2 #(
        .DATA_WIDTH  (DW),
        .RESET_VALUE (8'hA5),
        .EDGE_TYPE   (0),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .out_oe     (out_oe),
        .irq        (irq)
    );

    // Monitor: everything pushed since the previous negedge is compared here.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            case (e.sel)
                SEL_RDATA: act = readdata;
                SEL_OUT:   act = {24'h0, out_port};
                SEL_OE:    act = {24'h0, out_oe};
                default:   act = {31'h0, irq};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_sig(input string name, input int sel, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string name, input logic [2:0] addr, input logic [31:0] exp);
        address = addr;
        expect_sig(name, SEL_RDATA, exp);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        #1;
        expect_sig("rst_out_port", SEL_OUT, 32'hA5);
        expect_sig("rst_out_oe",   SEL_OE,  32'h00);
        expect_sig("rst_irq",      SEL_IRQ, 32'h0);
        cyc();
        reset_n = 1'b1;
        rd("rst_dir",  3'd1, 32'h0);
        rd("rst_mask", 3'd2, 32'h0);
        rd("rst_edge", 3'd3, 32'h0);
        rd("rst_data_in", 3'd0, 32'h0);
        cyc();

        // Data register, atomic set/clear, upper write bits ignored
        wr(3'd0, 32'h0000_003C);
        expect_sig("data_wr", SEL_OUT, 32'h3C);
        wr(3'd4, 32'h0000_0081);
        expect_sig("outset", SEL_OUT, 32'hBD);
        wr(3'd5, 32'h0000_000C);
        expect_sig("outclear", SEL_OUT, 32'hB1);
        wr(3'd0, 32'hFFFF_FF00);
        expect_sig("data_upper_ignored", SEL_OUT, 32'h00);
        rd("outset_read0", 3'd4, 32'h0);
        cyc();

        // Direction mux and input synchroniser latency
        wr(3'd1, 32'h0000_00F0);
        expect_sig("dir_oe", SEL_OE, 32'hF0);
        wr(3'd0, 32'h0000_00A0);
        in_port = 8'h05;
        cyc();
        rd("data_lat1", 3'd0, 32'hA0);
        cyc();
        rd("data_lat2", 3'd0, 32'hA5);
        rd("edge_nomask", 3'd3, 32'h05);
        expect_sig("irq_masked", SEL_IRQ, 32'h0);
        rd("addr6", 3'd6, 32'h0);
        rd("dir_read", 3'd1, 32'hF0);
        cyc();
        wr(3'd3, 32'h0000_00FF);
        rd("edge_w1c_all", 3'd3, 32'h0);

        // Rising capture on bit 0 with irq, falling ignored
        cyc();
        wr(3'd2, 32'h0000_0001);
        in_port = 8'h00;
        repeat (4) cyc();
        expect_sig("fall_irq", SEL_IRQ, 32'h0);
        rd("fall_nocap", 3'd3, 32'h0);
        cyc();
        in_port = 8'h01;
        cyc();
        cyc();
        expect_sig("irq_before", SEL_IRQ, 32'h0);
        rd("edge_before", 3'd3, 32'h0);
        cyc();
        expect_sig("irq_set", SEL_IRQ, 32'h1);
        rd("edge_set", 3'd3, 32'h01);
        cyc();
        wr(3'd3, 32'h0000_0001);
        expect_sig("irq_cleared", SEL_IRQ, 32'h0);
        rd("edge_cleared", 3'd3, 32'h0);

        // W1C in the same cycle as a detected edge: set wins
        cyc();
        in_port = 8'h00;
        repeat (4) cyc();
        in_port = 8'h01;
        cyc();
        cyc();
        address    = 3'd3;
        writedata  = 32'h0000_0001;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
        expect_sig("setwins_irq", SEL_IRQ, 32'h1);
        rd("setwins_edge", 3'd3, 32'h01);

        // Asynchronous reset mid-operation, then edge from a pin high at release
        cyc();
        #2;
        reset_n = 1'b0;
        expect_sig("arst_irq",  SEL_IRQ, 32'h0);
        expect_sig("arst_out",  SEL_OUT, 32'hA5);
        expect_sig("arst_oe",   SEL_OE,  32'h00);
        rd("arst_edge", 3'd3, 32'h0);
        rd("arst_mask", 3'd2, 32'h0);
        cyc();
        reset_n = 1'b1;
        cyc();
        cyc();
        rd("rel_edge_early", 3'd3, 32'h0);
        cyc();
        rd("rel_edge_set", 3'd3, 32'h01);
        expect_sig("rel_irq_masked", SEL_IRQ, 32'h0);

        @(negedge clk);
        #1;
        if (checks < MIN_CHECKS) begin
            errors++;
            $display("FAIL only %0d checks performed", checks);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        if (errors != 0) begin
            $display("FAIL");
        end else begin
            $display("PASS");
        end
        $finish;
    end

endmodule : tb_avalon_pio_gen2
`default_nettype wire
